systolic_operand_feeder: RTL and testbench
==========================================

# systolic_operand_feeder

Drives one edge of the processing-element array: accepts one N-lane operand vector per cycle through a valid/ready handshake and emits it diagonally skewed, with lane i delayed i cycles, so element k of every lane meets its partner in the correct PE. Drives the array enable, inserts zero bubbles when the source stalls, and flushes the skew pipeline at the end of each tile. One instance feeds the a-side of the array and a second feeds the b-side.

## Interface
- N, 4, number of lanes (array rows/cols); N >= 2
- W, 8, operand width in bits
- CW, 8, width of vector counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  source presents a vector
- in_ready  output  1  feeder accepts a vector this cycle
- in_data  input  N*W  lane i at bits [i*W +: W]
- in_last  input  1  accepted vector is the last of the tile
- skew_data  output  N*W  skewed operands to array (lane i at [i*W +: W])
- lane_valid  output  N  bit i: skew_data lane i carries real data
- en_out  output  1  array enable = OR of lane_valid
- tile_done  output  1  one-cycle pulse: last vector fully presented
- vec_count  output  CW  vectors accepted in current/most recent tile

## Operation
- Accept = in_valid && in_ready at a rising edge.
- Lane i is a shift line of depth i+1 (data + valid bit); lane 0 is a single register.
- Every cycle all lines shift. Line input is the accepted lane value with valid=1, otherwise zero with valid=0 (bubble). Bubbles never carry stale data.
- FSM states: IDLE, STREAM, FLUSH.
  - IDLE: in_ready=1. Accept without in_last -> STREAM. Accept with in_last -> FLUSH.
  - STREAM: in_ready=1. Accept with in_last -> FLUSH; otherwise stay.
  - FLUSH: in_ready=0; down-counter loaded with N-1 on entry, decremented each cycle; at 0 -> IDLE, tile_done pulses.
- vec_count: cleared to 1 on first accept of a tile (accept in IDLE), incremented on each later accept, saturating at 2^CW-1, held after the tile until the next tile starts.
- in_valid without in_ready: nothing accepted. in_data and in_last are ignored.
- Reset mid-tile: all lines, valid bits, counters and FSM cleared immediately. The partial tile is discarded and tile_done is not pulsed.

## Timing
- Reset values: in_ready=0, skew_data=0, lane_valid=0, en_out=0, tile_done=0, vec_count=0, state IDLE.
- in_ready is registered. It rises at the first rising edge after rst_n deasserts.
- Vector accepted at edge e: lane i shows its element and lane_valid[i]=1 after edge e+i, for exactly one cycle.
- en_out is combinational from the lane_valid registers, so it has the same timing.
- Last vector accepted at edge e: in_ready=0 from after edge e until after edge e+N-1. tile_done=1 and in_ready=1 during the cycle after edge e+N-1, which is the same cycle lane N-1 presents the last element.
- Back-to-back tiles: the next accept is possible at edge e+N. Minimum tile period is K+N-1 cycles for K vectors.
- Single-vector tile (first accept carries in_last): IDLE -> FLUSH directly. vec_count=1.
- Throughput is one vector per cycle in STREAM. No combinational path from in_valid to in_ready.

## Structure
- Shared package systolic_pkg holds:
  - default N and W
  - state enum {IDLE, STREAM, FLUSH}
  - the lane slice helper constant/function (i*W offset)
- Sub-module skew_delay_line (parameters DEPTH, W):
  - shift register carrying data plus a valid bit, asynchronous active-low clear
  - instantiated per lane with DEPTH=i+1 in a generate loop
- FSM, flush counter and vec_count sit in the top module.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release.
  - All outputs are 0 during reset.
  - in_ready=1 one edge after release.
  - en_out stays 0 with in_valid=0.
- Skew (N=4, W=8): send 3 consecutive vectors with lane values 0x11..0x14, 0x21..0x24 and 0x31..0x34, in_last on the third.
  - Lane i shows 0x1(i+1) after edge i, 0x2(i+1) after edge i+1, 0x3(i+1) after edge i+2.
  - en_out is high for 6 cycles.
  - tile_done pulses after edge 2+3.
  - vec_count=3.
- Stall bubbles: hold in_valid low for 2 cycles between vector 1 and vector 2.
  - Each lane shows two zero entries with lane_valid=0 between the vectors.
  - en_out stays high only while some lane is valid.
- Flush backpressure: keep in_valid=1 with a new vector right after the last accept.
  - in_ready stays 0 for 3 cycles and nothing is accepted.
  - The vector is accepted on the cycle tile_done=1 and starts a new tile with vec_count=1.
- Single-vector tile: one accept with in_last=1.
  - Exactly one diagonal appears on the lanes.
  - tile_done pulses 3 edges later.
  - vec_count=1.
- Reset mid-flush: assert rst_n low one cycle after the last accept.
  - skew_data, lane_valid and en_out clear immediately.
  - No tile_done pulse occurs, and vec_count=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array operand feeders.
package systolic_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Bit offset of lane i inside a packed N*W vector.
  function automatic int lane_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift line carrying an operand plus its valid flag.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
      r_valid <= '0;
    end else begin
      r_data[0]  <= i_data;
      r_valid[0] <= i_valid;
      for (int k = 1; k < DEPTH; k++) begin
        r_data[k]  <= r_data[k-1];
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_valid[DEPTH-1];

endmodule

// File: rtl/systolic_operand_feeder.sv
// Skews incoming operand vectors diagonally onto one edge of the PE array,
// inserting bubbles on source stalls and flushing the skew at tile end.
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int CW = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [N*W-1:0]  i_in_data,
  input  logic            i_in_last,
  output logic [N*W-1:0]  o_skew_data,
  output logic [N-1:0]    o_lane_valid,
  output logic            o_en_out,
  output logic            o_tile_done,
  output logic [CW-1:0]   o_vec_count
);

  localparam int FCW = (N > 2) ? $clog2(N) : 1;

  state_t          r_state, w_state_next;
  logic [FCW-1:0]  r_flush_cnt, w_flush_cnt_next;
  logic            r_in_ready, w_in_ready_next;
  logic            r_tile_done, w_tile_done_next;
  logic [CW-1:0]   r_vec_count, w_vec_count_next;
  logic            w_accept;

  assign w_accept = i_in_valid & r_in_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
      r_in_ready  <= 1'b0;
      r_tile_done <= 1'b0;
      r_vec_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_in_ready  <= w_in_ready_next;
      r_tile_done <= w_tile_done_next;
      r_vec_count <= w_vec_count_next;
    end
  end

  // Flush lasts N-1 edges so lane N-1 presents the last element as we leave.
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = i_in_last ? FLUSH : STREAM;
      end
      STREAM: begin
        if (w_accept && i_in_last) w_state_next = FLUSH;
      end
      FLUSH: begin
        w_flush_cnt_next = r_flush_cnt - FCW'(1);
        if (r_flush_cnt == FCW'(1)) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (r_state != FLUSH && w_state_next == FLUSH) w_flush_cnt_next = FCW'(N - 1);
  end

  always_comb begin
    w_in_ready_next  = (w_state_next != FLUSH);
    w_tile_done_next = (r_state == FLUSH) && (w_state_next == IDLE);
    w_vec_count_next = r_vec_count;
    if (w_accept) begin
      if (r_state == IDLE)         w_vec_count_next = CW'(1);
      else if (r_vec_count != '1)  w_vec_count_next = r_vec_count + CW'(1);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [W-1:0] w_lane_in;
    assign w_lane_in = w_accept ? i_in_data[lane_lo(gi, W) +: W] : '0;

    skew_delay_line #(
      .DEPTH (gi + 1),
      .W     (W)
    ) u_line (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (w_lane_in),
      .i_valid (w_accept),
      .o_data  (o_skew_data[lane_lo(gi, W) +: W]),
      .o_valid (o_lane_valid[gi])
    );
  end

  assign o_in_ready  = r_in_ready;
  assign o_en_out    = |o_lane_valid;
  assign o_tile_done = r_tile_done;
  assign o_vec_count = r_vec_count;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder (N=4, W=8, CW=8).
module tb_systolic_operand_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [31:0] skew_data;
  logic [3:0]  lane_valid;
  logic        en_out;
  logic        tile_done;
  logic [7:0]  vec_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int en_hi = 0;

  // What the bench intends to be accepted at each edge since the last reset.
  bit          hv [256];
  logic [31:0] hd [256];

  systolic_operand_feeder #(.N(4), .W(8), .CW(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .i_in_last    (in_last),
    .o_skew_data  (skew_data),
    .o_lane_valid (lane_valid),
    .o_en_out     (en_out),
    .o_tile_done  (tile_done),
    .o_vec_count  (vec_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane i = base + i + 1.
  function automatic logic [31:0] vec(input logic [7:0] base);
    return {base + 8'd4, base + 8'd3, base + 8'd2, base + 8'd1};
  endfunction

  task automatic clear_hist();
    for (int k = 0; k < 256; k++) begin
      hv[k] = 1'b0;
      hd[k] = '0;
    end
    cyc = 0;
  endtask

  // One clock: drive, sample 1 time unit after the edge, compare everything.
  task automatic step(input string tag, input bit v, input logic [31:0] d, input bit last,
                      input bit acc, input bit rdy, input bit done);
    logic [31:0] ed;
    logic [3:0]  ev;
    in_valid = v;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    hv[cyc] = acc;
    hd[cyc] = d;
    ed = '0;
    ev = '0;
    for (int i = 0; i < 4; i++) begin
      if (cyc - i >= 0 && hv[cyc-i]) begin
        ed[i*8 +: 8] = hd[cyc-i][i*8 +: 8];
        ev[i] = 1'b1;
      end
    end
    check_eq({tag, "_data"}, 64'(skew_data), 64'(ed));
    check_eq({tag, "_lv"}, 64'(lane_valid), 64'(ev));
    check_eq({tag, "_en"}, 64'(en_out), 64'(|ev));
    check_eq({tag, "_rdy"}, 64'(in_ready), 64'(rdy));
    check_eq({tag, "_done"}, 64'(tile_done), 64'(done));
    $display("step %-10s cyc=%0d v=%0b d=%h last=%0b | rdy=%0b lv=%b data=%h en=%0b done=%0b cnt=%0d",
             tag, cyc, v, d, last, in_ready, lane_valid, skew_data, en_out, tile_done, vec_count);
    if (en_out) en_hi++;
    cyc++;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  initial begin
    clear_hist();

    // Reset / idle
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_rdy", 64'(in_ready), 64'd0);
      check_eq("rst_data", 64'(skew_data), 64'd0);
      check_eq("rst_lv", 64'(lane_valid), 64'd0);
      check_eq("rst_en", 64'(en_out), 64'd0);
      check_eq("rst_done", 64'(tile_done), 64'd0);
      check_eq("rst_cnt", 64'(vec_count), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("idle0", 0, '0, 0, 0, 1, 0);
    step("idle1", 0, '0, 0, 0, 1, 0);
    step("idle2", 0, '0, 0, 0, 1, 0);

    // Skew: three back-to-back vectors, last on the third
    en_hi = 0;
    step("sk_v1", 1, vec(8'h10), 0, 1, 1, 0);
    step("sk_v2", 1, vec(8'h20), 0, 1, 1, 0);
    step("sk_v3", 1, vec(8'h30), 1, 1, 0, 0);
    step("sk_f1", 0, '0, 0, 0, 0, 0);
    step("sk_f2", 0, '0, 0, 0, 0, 0);
    step("sk_f3", 0, '0, 0, 0, 1, 1);
    step("sk_end", 0, '0, 0, 0, 1, 0);
    check_eq("sk_en_cycles", 64'(en_hi), 64'd6);
    check_eq("sk_cnt", 64'(vec_count), 64'd3);

    // Stall bubbles: two idle cycles between vector 1 and vector 2
    step("st_v1", 1, vec(8'h40), 0, 1, 1, 0);
    step("st_b1", 0, 32'hdeadbeef, 0, 0, 1, 0);
    step("st_b2", 0, 32'hcafef00d, 0, 0, 1, 0);
    step("st_v2", 1, vec(8'h50), 1, 1, 0, 0);
    step("st_f1", 0, '0, 0, 0, 0, 0);
    step("st_f2", 0, '0, 0, 0, 0, 0);
    step("st_f3", 0, '0, 0, 0, 1, 1);
    step("st_end", 0, '0, 0, 0, 1, 0);
    check_eq("st_cnt", 64'(vec_count), 64'd2);

    // Flush backpressure: next vector held valid through the flush
    step("bp_a", 1, vec(8'h60), 1, 1, 0, 0);
    step("bp_w1", 1, vec(8'h70), 0, 0, 0, 0);
    step("bp_w2", 1, vec(8'h70), 0, 0, 0, 0);
    step("bp_w3", 1, vec(8'h70), 0, 0, 1, 1);
    step("bp_b", 1, vec(8'h70), 1, 1, 0, 0);
    check_eq("bp_cnt", 64'(vec_count), 64'd1);
    step("bp_f1", 0, '0, 0, 0, 0, 0);
    step("bp_f2", 0, '0, 0, 0, 0, 0);
    step("bp_f3", 0, '0, 0, 0, 1, 1);
    step("bp_end", 0, '0, 0, 0, 1, 0);

    // Single-vector tile
    step("sv_a", 1, vec(8'h80), 1, 1, 0, 0);
    step("sv_f1", 0, '0, 0, 0, 0, 0);
    step("sv_f2", 0, '0, 0, 0, 0, 0);
    step("sv_f3", 0, '0, 0, 0, 1, 1);
    step("sv_end", 0, '0, 0, 0, 1, 0);
    check_eq("sv_cnt", 64'(vec_count), 64'd1);

    // Reset during flush
    step("rm_v0", 1, vec(8'h90), 0, 1, 1, 0);
    step("rm_v1", 1, vec(8'hA0), 1, 1, 0, 0);
    step("rm_gap", 0, '0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rm_data", 64'(skew_data), 64'd0);
    check_eq("rm_lv", 64'(lane_valid), 64'd0);
    check_eq("rm_en", 64'(en_out), 64'd0);
    check_eq("rm_rdy", 64'(in_ready), 64'd0);
    check_eq("rm_cnt", 64'(vec_count), 64'd0);
    check_eq("rm_done", 64'(tile_done), 64'd0);
    clear_hist();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step("rm_post", 0, '0, 0, 0, 1, 0);
    check_eq("rm_cnt_post", 64'(vec_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
